// File: rtl/ecc_scrub_scheduler.sv
// rtl/ecc_scrub_scheduler.sv - ECC scrub burst scheduler with starvation override and error counters (optional ECC_SCRUB_ESCALATE_EN)
module ecc_scrub_scheduler #(
    parameter int BurstLen    = 16,
    parameter int StarveLimit = 64,
    parameter int CntWidth    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [CntWidth-1:0] cfg_interval_i,
    input  logic                clear_i,
    input  logic                intc_busy_i,
    input  logic                scrub_step_i,
    input  logic                bit_corrected_i,
    input  logic                uncorrectable_i,
    output logic                scrub_trigger_o,
    output logic                force_prio_o,
    output logic [CntWidth-1:0] corrected_cnt_o,
    output logic [CntWidth-1:0] uncorrectable_cnt_o,
    output logic                irq_o
);

    localparam int StepW   = $clog2(BurstLen + 1);
    localparam int StarveW = $clog2(StarveLimit + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SCRUB = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CntWidth-1:0]  icnt_q;
    logic [StepW-1:0]     step_cnt_q;
    logic [StarveW-1:0]   starve_q;
    logic [StarveW-1:0]   starve_nxt;
    logic                 force_q;
    logic [CntWidth-1:0]  corr_q, unc_q;
    logic                 irq_q;
    logic                 burst_done;
    logic                 escalate;
    logic                 load_interval;
    logic                 in_scrub_both;

`ifdef ECC_SCRUB_ESCALATE_EN
    logic pend_q;

    // A correction seen during a burst (including on its final step) forces an immediate follow-on burst.
    assign escalate = pend_q | bit_corrected_i;

    // Pending-escalation flag: set by corrections in SCRUB, consumed at burst end, dropped on disable.
    always_ff @(posedge clk_i) begin
        if (rst_i || !enable_i) begin
            pend_q <= 1'b0;
        end else if (state_q == ST_SCRUB) begin
            if (burst_done) begin
                pend_q <= 1'b0;
            end else if (bit_corrected_i) begin
                pend_q <= 1'b1;
            end
        end
    end
`else
    assign escalate = 1'b0;
`endif

    // Starvation count only advances on busy cycles without progress; it saturates at the limit.
    assign starve_nxt = (state_q == ST_SCRUB && !scrub_step_i && intc_busy_i &&
                         starve_q != StarveW'(StarveLimit)) ? starve_q + 1'b1 : starve_q;

    // Next-state decode; disable overrides everything and returns to IDLE.
    always_comb begin
        state_d       = state_q;
        burst_done    = (state_q == ST_SCRUB) && scrub_step_i &&
                        (step_cnt_q == StepW'(BurstLen - 1));
        case (state_q)
            ST_IDLE:  state_d = (cfg_interval_i != '0) ? ST_WAIT : ST_SCRUB;
            ST_WAIT:  if (icnt_q == CntWidth'(1)) state_d = ST_SCRUB;
            ST_SCRUB: if (burst_done && !escalate && cfg_interval_i != '0) state_d = ST_WAIT;
            default:  state_d = ST_IDLE;
        endcase
        if (!enable_i) begin
            state_d = ST_IDLE;
        end
        load_interval = (state_d == ST_WAIT) && (state_q != ST_WAIT);
        in_scrub_both = (state_d == ST_SCRUB) && (state_q == ST_SCRUB);
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Interval countdown, burst step counter and starvation override.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            icnt_q     <= '0;
            step_cnt_q <= '0;
            starve_q   <= '0;
            force_q    <= 1'b0;
        end else begin
            if (load_interval) begin
                icnt_q <= cfg_interval_i;
            end else if (state_q == ST_WAIT) begin
                icnt_q <= icnt_q - 1'b1;
            end
            if (!in_scrub_both) begin
                step_cnt_q <= '0;
                starve_q   <= '0;
                force_q    <= 1'b0;
            end else if (scrub_step_i) begin
                step_cnt_q <= burst_done ? '0 : step_cnt_q + 1'b1;
                starve_q   <= '0;
                force_q    <= 1'b0;
            end else begin
                starve_q   <= starve_nxt;
                force_q    <= (starve_nxt == StarveW'(StarveLimit));
            end
        end
    end

    // Saturating error counters and sticky interrupt; clear wins over a same-cycle event.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            corr_q <= '0;
            unc_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (bit_corrected_i && corr_q != '1) corr_q <= corr_q + 1'b1;
            if (uncorrectable_i && unc_q != '1)  unc_q  <= unc_q + 1'b1;
            if (uncorrectable_i)                 irq_q  <= 1'b1;
        end
    end

    assign scrub_trigger_o     = (state_q == ST_SCRUB);
    assign force_prio_o        = force_q;
    assign corrected_cnt_o     = corr_q;
    assign uncorrectable_cnt_o = unc_q;
    assign irq_o               = irq_q;

endmodule

// File: tb/tb_ecc_scrub_scheduler.sv
// tb/tb_ecc_scrub_scheduler.sv - scoreboard bench for ecc_scrub_scheduler against a behavioural model
module tb_ecc_scrub_scheduler;

    localparam int BURST = 16;
    localparam int LIMIT = 64;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;
`ifdef ECC_SCRUB_ESCALATE_EN
    localparam bit ESC = 1'b1;
`else
    localparam bit ESC = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          enable_i;
    logic [CW-1:0] cfg_interval_i;
    logic          clear_i, intc_busy_i, scrub_step_i, bit_corrected_i, uncorrectable_i;
    logic          scrub_trigger_o, force_prio_o, irq_o;
    logic [CW-1:0] corrected_cnt_o, uncorrectable_cnt_o;

    ecc_scrub_scheduler #(.BurstLen(BURST), .StarveLimit(LIMIT), .CntWidth(CW)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .enable_i           (enable_i),
        .cfg_interval_i     (cfg_interval_i),
        .clear_i            (clear_i),
        .intc_busy_i        (intc_busy_i),
        .scrub_step_i       (scrub_step_i),
        .bit_corrected_i    (bit_corrected_i),
        .uncorrectable_i    (uncorrectable_i),
        .scrub_trigger_o    (scrub_trigger_o),
        .force_prio_o       (force_prio_o),
        .corrected_cnt_o    (corrected_cnt_o),
        .uncorrectable_cnt_o(uncorrectable_cnt_o),
        .irq_o              (irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic          trig;
        logic          force_p;
        logic [CW-1:0] corr;
        logic [CW-1:0] unc;
        logic          irq;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase of the schedule plus plain integer bookkeeping.
    typedef enum {PH_IDLE, PH_WAIT, PH_SCRUB} phase_t;
    phase_t m_phase = PH_IDLE;
    int     m_remaining = 0, m_steps = 0, m_starve = 0, m_corr = 0, m_unc = 0;
    bit     m_force = 0, m_irq = 0, m_pend = 0;

    function automatic void model_step();
        exp_t   e;
        phase_t prev;
        if (rst_i) begin
            m_phase = PH_IDLE; m_remaining = 0; m_steps = 0; m_starve = 0;
            m_corr = 0; m_unc = 0; m_force = 0; m_irq = 0; m_pend = 0;
        end else begin
            if (clear_i) begin
                m_corr = 0; m_unc = 0; m_irq = 0;
            end else begin
                if (bit_corrected_i) m_corr = (m_corr == CMAX) ? CMAX : m_corr + 1;
                if (uncorrectable_i) m_unc  = (m_unc  == CMAX) ? CMAX : m_unc + 1;
                if (uncorrectable_i) m_irq  = 1;
            end
            prev = m_phase;
            if (!enable_i) begin
                m_phase = PH_IDLE; m_pend = 0;
            end else if (m_phase == PH_IDLE) begin
                if (cfg_interval_i != 0) begin
                    m_phase = PH_WAIT; m_remaining = int'(cfg_interval_i);
                end else begin
                    m_phase = PH_SCRUB;
                end
            end else if (m_phase == PH_WAIT) begin
                m_remaining--;
                if (m_remaining == 0) m_phase = PH_SCRUB;
            end else begin
                if (ESC && bit_corrected_i) m_pend = 1;
                if (scrub_step_i) begin
                    m_steps++; m_starve = 0; m_force = 0;
                    if (m_steps == BURST) begin
                        m_steps = 0;
                        if (m_pend) begin
                            m_pend = 0;
                        end else if (cfg_interval_i != 0) begin
                            m_phase = PH_WAIT; m_remaining = int'(cfg_interval_i);
                        end
                    end
                end else begin
                    if (intc_busy_i && m_starve < LIMIT) m_starve++;
                    m_force = (m_starve >= LIMIT);
                end
            end
            if (prev != PH_SCRUB || m_phase != PH_SCRUB) begin
                m_steps = 0; m_starve = 0; m_force = 0;
            end
        end
        e.trig    = (m_phase == PH_SCRUB);
        e.force_p = m_force;
        e.corr    = CW'(m_corr);
        e.unc     = CW'(m_unc);
        e.irq     = m_irq;
        exp_q.push_back(e);
    endfunction

    // Applies one cycle of stimulus on the falling edge and records what must follow the next rising edge.
    task automatic cycle(input bit rst, input bit en, input int cfg, input bit busy,
                         input bit step, input bit bc, input bit uc, input bit clr);
        @(negedge clk_i);
        rst_i = rst; enable_i = en; cfg_interval_i = CW'(cfg); intc_busy_i = busy;
        scrub_step_i = step; bit_corrected_i = bc; uncorrectable_i = uc; clear_i = clr;
        model_step();
    endtask

    // Monitor: compares the DUT against the oldest expectation shortly after each rising edge.
    always @(posedge clk_i) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e, a;
            e = exp_q.pop_front();
            a = '{scrub_trigger_o, force_prio_o, corrected_cnt_o, uncorrectable_cnt_o, irq_o};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs @%0t: got trig=%b force=%b corr=%0d unc=%0d irq=%b, want trig=%b force=%b corr=%0d unc=%0d irq=%b",
                         $time, a.trig, a.force_p, a.corr, a.unc, a.irq,
                         e.trig, e.force_p, e.corr, e.unc, e.irq);
            end
        end
    end

    initial begin
        int cfg;
        rst_i = 1; enable_i = 0; cfg_interval_i = '0; intc_busy_i = 0;
        scrub_step_i = 0; bit_corrected_i = 0; uncorrectable_i = 0; clear_i = 0;

        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0);

        // Interval 10, a step every other cycle.
        for (int i = 0; i < 120; i++) cycle(0, 1, 10, 0, i[0], 0, 0, 0);
        // Back-to-back bursts.
        for (int i = 0; i < 80; i++) cycle(0, 1, 0, 0, i[0], 0, 0, 0);
        // Starvation under traffic, then one step releases the override.
        for (int i = 0; i < 70; i++) cycle(0, 1, 0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0);
        // Corrected-count saturation.
        for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0, 0, 1, 0, 0);
        // Uncorrectable, then clear colliding with another uncorrectable.
        cycle(0, 1, 0, 0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 0, 0, 1, 1);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        // Disable after 5 steps of a burst, re-enable into a fresh burst with a WAIT afterwards.
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 6, 0, 1, 0, 0, 0);
        cycle(0, 0, 6, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) cycle(0, 1, 6, 0, 1, 0, 0, 0);
        // A correction mid-burst with a non-zero interval (escalation when enabled).
        for (int i = 0; i < 60; i++) cycle(0, 1, 5, 0, 1, (i == 20), 0, 0);

        // Randomized traffic.
        cfg = 3;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) cfg = $urandom_range(0, 6);
            cycle($urandom_range(0, 999) == 0, $urandom_range(0, 59) != 0, cfg,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
                  $urandom_range(0, 79) == 0);
        end

        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
